alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares one `alu_rtl` instance between NUM_REQ independent requesters.
- Each requester presents a complete ALU operation with a valid/ready handshake.
- The arbiter grants requesters in round-robin order and drives the ALU for the required number of cycles.
- It captures the ALU outputs and returns them on a single tagged response channel with backpressure. It sits between the command sources and the ALU datapath.

Parameters:
- WIDTH, 4, ALU operand width. ALU result is 2*WIDTH.
- CMD_WIDTH, 4, ALU command width.
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index; must satisfy 2**ID_W >= NUM_REQ.
- ALU_LAT, 2, cycles from issue to valid ALU outputs for ordinary commands.
- MUL_LAT, 3, cycles from issue to valid ALU outputs for multiply commands (MODE=1, CMD=9 or 10).

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_opa  in  NUM_REQ*WIDTH  packed operand A; requester i at [i*WIDTH +: WIDTH].
- req_opb  in  NUM_REQ*WIDTH  packed operand B.
- req_cmd  in  NUM_REQ*CMD_WIDTH  packed command.
- req_mode  in  NUM_REQ  1 = arithmetic, 0 = logical.
- req_cin  in  NUM_REQ  carry in.
- req_inp_valid  in  NUM_REQ*2  packed operand-valid pair.
- alu_opa, alu_opb  out  WIDTH  to ALU.
- alu_cmd  out  CMD_WIDTH  to ALU.
- alu_mode, alu_cin, alu_ce  out  1  to ALU.
- alu_inp_valid  out  2  to ALU.
- alu_res  in  2*WIDTH  from ALU.
- alu_cout, alu_oflow, alu_err  in  1  from ALU.
- alu_egl  in  3  from ALU, ordered {E,G,L}.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the requester that issued the operation.
- rsp_res  out  2*WIDTH  captured ALU result.
- rsp_cout, rsp_oflow, rsp_err  out  1  captured ALU flags.
- rsp_egl  out  3  captured {E,G,L}.

Behaviour:
- Reset (RST=0, async):
  - State goes to IDLE; rr_ptr=0; lat_cnt=0.
  - All outputs are 0, including alu_ce, alu_inp_valid, req_ready and rsp_valid.
  - An in-flight operation is dropped with no response.
- States are IDLE, EXEC and RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching from rr_ptr upward with wrap at NUM_REQ.
  - req_ready[grant]=1 combinationally; req_ready is 0 in every other state.
  - On req_valid[g] & req_ready[g], all fields of g are registered into alu_*.
  - Also on that handshake: id <= g; lat_cnt <= MUL_LAT if the command is a multiply, else ALU_LAT; next state EXEC.
  - If no request is valid, stay in IDLE.
- EXEC:
  - alu_ce=1; alu_* are held constant.
  - lat_cnt decrements each cycle.
  - In the cycle where lat_cnt==1, the next edge captures alu_res/flags into rsp_*, sets rsp_valid=1 and moves to RESP.
  - EXEC therefore lasts exactly lat cycles. Handshake at cycle t gives rsp_valid high at t+1+lat.
- RESP:
  - alu_ce=0 and alu_inp_valid=0; rsp_* are held stable.
  - On rsp_valid & rsp_ready: rsp_valid <= 0; rr_ptr <= (id+1) mod NUM_REQ; next state IDLE.
  - rsp_ready asserted outside RESP has no effect.
- Throughput is at most one operation per lat+2 cycles. A new grant is never issued while a response is pending.
- A requester may drop req_valid before it is granted with no side effect. An accepted operation cannot be cancelled.
- The arbiter does not check commands. The ALU's ERR (invalid command, INP_VALID=00, etc.) is passed through in rsp_err.
- rr_ptr advances only on response completion, so no requester waits more than NUM_REQ-1 operations once valid.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined:
  - Adds an output port stat_grants (NUM_REQ*16).
  - Adds per-requester 16-bit grant counters, incremented on each request handshake and saturating at 16'hFFFF.
  - Counters reset to 0 on RST.
- When undefined, neither the port nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- Package alu_arb_pkg holds:
  - state encodings IDLE=2'd0, EXEC=2'd1, RESP=2'd2;
  - multiply command codes CMD_MUL_INC=4'd9 and CMD_MUL_SHL=4'd10;
  - a function is_mul(mode, cmd).
- One sub-module is natural: rr_arbiter, a pure round-robin priority picker with inputs req, ptr and outputs grant_onehot, grant_idx, any.

Test Plan:
- Single ADD:
  - Stimulus: req0 with MODE=1, CMD=0, OPA=3, OPB=5, INP_VALID=11, rsp_ready=1.
  - Required: req_ready[0] at t; rsp_valid at t+3 with rsp_res=8, rsp_id=0, cout=0, err=0.
- Round-robin:
  - Stimulus: all four req_valid held high.
  - Required: rsp_id sequence 0,1,2,3,0.
- Multiply latency:
  - Stimulus: req2 with MODE=1, CMD=9, OPA=3, OPB=3.
  - Required: rsp_valid at t+4, rsp_res=16, rsp_id=2.
- Backpressure:
  - Stimulus: compare MODE=1, CMD=8, OPA=5, OPB=5, with rsp_ready low for 5 cycles.
  - Required: rsp_egl=3'b100 held stable; no req_ready during the stall; a new grant occurs one cycle after the accept.
- Reset mid-EXEC:
  - Stimulus: RST low for one cycle during EXEC.
  - Required: all outputs immediately 0, no response, next grant starts from requester 0.
- STATS (ALU_ARB_STATS_EN only):
  - Stimulus: 3 grants to req1.
  - Required: stat_grants[16 +: 16]=3; other counters 0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared definitions for the ALU request arbiter.
//   arb_state_t  - arbiter FSM encoding
//   CMD_MUL_*    - arithmetic-mode command codes that take the long latency
//   is_mul()     - true when (mode, cmd) selects a multiply
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [3:0] CMD_MUL_INC = 4'd9;
  localparam logic [3:0] CMD_MUL_SHL = 4'd10;

  // Command is passed zero-extended to 8 bits so any CMD_WIDTH up to 8 compares exactly.
  function automatic logic is_mul(input logic mode, input logic [7:0] cmd);
    return mode && ((cmd == {4'd0, CMD_MUL_INC}) || (cmd == {4'd0, CMD_MUL_SHL}));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin priority picker (pure combinational).
//   req          - request vector
//   ptr          - highest-priority index this round
//   grant_onehot - one-hot grant, zero when nothing requests
//   grant_idx    - binary index of the grant
//   any          - at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;

  // Rotating a doubled copy puts requester ptr at bit 0, so the lowest set bit wins.
  assign w_dbl = {req, req};
  assign w_rot = NUM_REQ'(w_dbl >> ptr);

  always_comb begin
    any          = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    // Scanning downward lets the lowest rotated position overwrite higher ones.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        any       = 1'b1;
        grant_idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
    if (any) grant_onehot = NUM_REQ'(1) << grant_idx;
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one ALU between NUM_REQ requesters, round-robin,
// one operation in flight, tagged response channel with backpressure.
//   CLK, RST            - clock, async active-low reset
//   req_*               - per-requester packed operation + valid/ready
//   alu_*               - drive to / results from the shared ALU
//   rsp_*               - tagged captured result, valid/ready
//   stat_grants         - per-requester saturating grant counters
//                         (only when ALU_ARB_STATS_EN is defined)
//
// state | meaning
// IDLE  | pick a requester, accept its operation into alu_*
// EXEC  | ALU enabled, count down the command latency
// RESP  | result held on rsp_*, waiting for rsp_ready
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CMD_WIDTH = 4,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int ALU_LAT   = 2,
  parameter int MUL_LAT   = 3
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]     req_opa,
  input  logic [NUM_REQ*WIDTH-1:0]     req_opb,
  input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd,
  input  logic [NUM_REQ-1:0]           req_mode,
  input  logic [NUM_REQ-1:0]           req_cin,
  input  logic [NUM_REQ*2-1:0]         req_inp_valid,
  output logic [WIDTH-1:0]             alu_opa,
  output logic [WIDTH-1:0]             alu_opb,
  output logic [CMD_WIDTH-1:0]         alu_cmd,
  output logic                         alu_mode,
  output logic                         alu_cin,
  output logic                         alu_ce,
  output logic [1:0]                   alu_inp_valid,
  input  logic [2*WIDTH-1:0]           alu_res,
  input  logic                         alu_cout,
  input  logic                         alu_oflow,
  input  logic                         alu_err,
  input  logic [2:0]                   alu_egl,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [2*WIDTH-1:0]           rsp_res,
  output logic                         rsp_cout,
  output logic                         rsp_oflow,
  output logic                         rsp_err,
  output logic [2:0]                   rsp_egl
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]        stat_grants
`endif
);

  localparam int LAT_MAX = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int LAT_W   = $clog2(LAT_MAX + 1);

  arb_state_t           r_state, w_next;
  logic [ID_W-1:0]      r_rr_ptr, r_id, w_gidx;
  logic [LAT_W-1:0]     r_lat_cnt;
  logic [1:0]           r_inp_valid;
  logic [NUM_REQ-1:0]   w_gonehot;
  logic                 w_any, w_hs, w_last;
  logic [WIDTH-1:0]     w_sel_opa, w_sel_opb;
  logic [CMD_WIDTH-1:0] w_sel_cmd;
  logic                 w_sel_mode, w_sel_cin;
  logic [1:0]           w_sel_iv;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req          (req_valid),
    .ptr          (r_rr_ptr),
    .grant_onehot (w_gonehot),
    .grant_idx    (w_gidx),
    .any          (w_any)
  );

  always_comb begin
    w_sel_opa  = '0;
    w_sel_opb  = '0;
    w_sel_cmd  = '0;
    w_sel_mode = 1'b0;
    w_sel_cin  = 1'b0;
    w_sel_iv   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gidx == ID_W'(i)) begin
        w_sel_opa  = req_opa[i*WIDTH +: WIDTH];
        w_sel_opb  = req_opb[i*WIDTH +: WIDTH];
        w_sel_cmd  = req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
        w_sel_mode = req_mode[i];
        w_sel_cin  = req_cin[i];
        w_sel_iv   = req_inp_valid[i*2 +: 2];
      end
    end
  end

  // Gating with RST keeps req_ready low while reset is held even though it is combinational.
  assign req_ready     = (r_state == IDLE && RST) ? w_gonehot : '0;
  assign w_hs          = (r_state == IDLE) && w_any;
  assign w_last        = (r_lat_cnt == LAT_W'(1));
  assign alu_ce        = (r_state == EXEC);
  assign alu_inp_valid = (r_state == EXEC) ? r_inp_valid : 2'b00;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next = EXEC;
      EXEC:    if (w_last) w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_lat_cnt   <= '0;
      r_inp_valid <= '0;
      alu_opa     <= '0;
      alu_opb     <= '0;
      alu_cmd     <= '0;
      alu_mode    <= 1'b0;
      alu_cin     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_res     <= '0;
      rsp_cout    <= 1'b0;
      rsp_oflow   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_egl     <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_hs) begin
          alu_opa     <= w_sel_opa;
          alu_opb     <= w_sel_opb;
          alu_cmd     <= w_sel_cmd;
          alu_mode    <= w_sel_mode;
          alu_cin     <= w_sel_cin;
          r_inp_valid <= w_sel_iv;
          r_id        <= w_gidx;
          r_lat_cnt   <= is_mul(w_sel_mode, 8'(w_sel_cmd)) ? LAT_W'(MUL_LAT) : LAT_W'(ALU_LAT);
        end
        EXEC: begin
          r_lat_cnt <= r_lat_cnt - 1'b1;
          if (w_last) begin
            rsp_valid <= 1'b1;
            rsp_id    <= r_id;
            rsp_res   <= alu_res;
            rsp_cout  <= alu_cout;
            rsp_oflow <= alu_oflow;
            rsp_err   <= alu_err;
            rsp_egl   <= alu_egl;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          // Priority moves past the requester just served, only once its result is taken.
          r_rr_ptr  <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] r_stat [NUM_REQ];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NUM_REQ; i++) r_stat[i] <= '0;
    end else if (w_hs) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (w_gonehot[i] && r_stat[i] != 16'hFFFF) r_stat[i] <= r_stat[i] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_grants[g*16 +: 16] = r_stat[g];
  end
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  req_valid, req_ready, req_mode, req_cin;
  logic [15:0] req_opa, req_opb, req_cmd;
  logic [7:0]  req_inp_valid;
  logic [3:0]  alu_opa, alu_opb, alu_cmd;
  logic        alu_mode, alu_cin, alu_ce;
  logic [1:0]  alu_inp_valid;
  logic [7:0]  alu_res;
  logic        alu_cout, alu_oflow, alu_err;
  logic [2:0]  alu_egl;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_res;
  logic        rsp_cout, rsp_oflow, rsp_err;
  logic [2:0]  rsp_egl;
`ifdef ALU_ARB_STATS_EN
  logic [63:0] stat_grants;
`endif

  int checks = 0;
  int errors = 0;

  alu_req_arbiter dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd),
    .req_mode(req_mode), .req_cin(req_cin), .req_inp_valid(req_inp_valid),
    .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cmd(alu_cmd),
    .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_ce(alu_ce),
    .alu_inp_valid(alu_inp_valid),
    .alu_res(alu_res), .alu_cout(alu_cout), .alu_oflow(alu_oflow),
    .alu_err(alu_err), .alu_egl(alu_egl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_cout(rsp_cout), .rsp_oflow(rsp_oflow),
    .rsp_err(rsp_err), .rsp_egl(rsp_egl)
`ifdef ALU_ARB_STATS_EN
    , .stat_grants(stat_grants)
`endif
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU stand-in: outputs are garbage until the command's latency has elapsed
  // with alu_ce high, so early or late capture shows up as a wrong response.
  logic [7:0] tb_cnt;
  logic [7:0] tb_sum;
  int         tb_need;

  always @(posedge CLK or negedge RST) begin
    if (!RST)        tb_cnt <= 8'd0;
    else if (alu_ce) tb_cnt <= tb_cnt + 8'd1;
    else             tb_cnt <= 8'd0;
  end

  always_comb begin
    tb_need   = (alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10)) ? 3 : 2;
    tb_sum    = {4'd0, alu_opa} + {4'd0, alu_opb} + {7'd0, alu_cin};
    alu_res   = 8'hEE;
    alu_cout  = 1'b1;
    alu_oflow = 1'b1;
    alu_err   = 1'b1;
    alu_egl   = 3'b111;
    if (alu_ce && int'(tb_cnt) >= tb_need - 1) begin
      alu_res   = 8'h00;
      alu_cout  = 1'b0;
      alu_oflow = 1'b0;
      alu_egl   = 3'b000;
      alu_err   = (alu_inp_valid == 2'b00);
      if (!alu_mode) alu_res = {4'd0, alu_opa & alu_opb};
      else case (alu_cmd)
        4'd0:  begin alu_res = tb_sum; alu_cout = tb_sum[4]; end
        4'd8:  alu_egl = {alu_opa == alu_opb, alu_opa > alu_opb, alu_opa < alu_opb};
        4'd9:  alu_res = ({4'd0, alu_opa} + 8'd1) * ({4'd0, alu_opb} + 8'd1);
        4'd10: alu_res = {3'd0, alu_opa, 1'b0} * {4'd0, alu_opb};
        default: alu_err = 1'b1;
      endcase
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic m, input logic [3:0] c,
                         input logic [3:0] a, input logic [3:0] b, input logic ci,
                         input logic [1:0] iv);
    req_mode[i]           = m;
    req_cmd[i*4 +: 4]     = c;
    req_opa[i*4 +: 4]     = a;
    req_opb[i*4 +: 4]     = b;
    req_cin[i]            = ci;
    req_inp_valid[i*2 +: 2] = iv;
  endtask

  task automatic pulse_reset();
    RST = 1'b0;
    #2;
    RST = 1'b1;
    step();
  endtask

  task automatic wait_rsp(input string tag);
    for (int w = 0; w < 12 && rsp_valid !== 1'b1; w++) step();
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout rsp_valid got %b exp 1", tag, rsp_valid);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    req_valid = 4'b1111;
    #2;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got %b exp 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (alu_ce !== 1'b0 || alu_inp_valid !== 2'b00) begin errors++; $display("FAIL rst_alu_ce got %b/%b exp 0/00", alu_ce, alu_inp_valid); end
    checks++; if (alu_opa !== 4'd0 || alu_cmd !== 4'd0 || rsp_res !== 8'd0 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL rst_regs got opa=%h cmd=%h res=%h id=%0d exp all 0", alu_opa, alu_cmd, rsp_res, rsp_id);
    end
    req_valid = 4'b0000;
    step();
    RST = 1'b1;
    step();
  endtask

  task automatic test_single_add();
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 4'd0, 4'd3, 4'd5, 1'b0, 2'b11);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL add_ready got %b exp 0001", req_ready); end
    step();
    req_valid = 4'b0000;
    checks++; if (alu_ce !== 1'b1 || alu_opa !== 4'd3 || alu_opb !== 4'd5 || alu_inp_valid !== 2'b11) begin
      errors++; $display("FAIL add_issue got ce=%b a=%0d b=%0d iv=%b exp 1 3 5 11", alu_ce, alu_opa, alu_opb, alu_inp_valid);
    end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_early1 rsp_valid got %b exp 0", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_early2 rsp_valid got %b exp 0", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_res !== 8'd8 || rsp_id !== 2'd0 || rsp_cout !== 1'b0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL add_rsp got v=%b res=%0d id=%0d cout=%b err=%b exp 1 8 0 0 0", rsp_valid, rsp_res, rsp_id, rsp_cout, rsp_err);
    end
    checks++; if (alu_ce !== 1'b0 || alu_inp_valid !== 2'b00) begin errors++; $display("FAIL add_resp_alu got ce=%b iv=%b exp 0 00", alu_ce, alu_inp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_accept rsp_valid got %b exp 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'd0, 4'(i), 4'd1, 1'b0, 2'b11);
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_rsp("rr");
      checks++; if (rsp_id !== 2'(n % 4) || rsp_res !== 8'(n % 4 + 1)) begin
        errors++; $display("FAIL rr_op%0d got id=%0d res=%0d exp id=%0d res=%0d", n, rsp_id, rsp_res, n % 4, n % 4 + 1);
      end
      if (n == 4) req_valid = 4'b0000;
      step();
    end
  endtask

  task automatic test_mul();
    rsp_ready = 1'b1;
    set_req(2, 1'b1, 4'd9, 4'd3, 4'd3, 1'b0, 2'b11);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mul_ready got %b exp 0100", req_ready); end
    step();
    req_valid = 4'b0000;
    step();
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mul_early rsp_valid got %b exp 0", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_res !== 8'd16 || rsp_id !== 2'd2) begin
      errors++; $display("FAIL mul_rsp got v=%b res=%0d id=%0d exp 1 16 2", rsp_valid, rsp_res, rsp_id);
    end
    step();
  endtask

  task automatic test_back_pressure();
    rsp_ready = 1'b0;
    set_req(3, 1'b1, 4'd8, 4'd5, 4'd5, 1'b0, 2'b11);
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_ready got %b exp 1000", req_ready); end
    step();
    set_req(0, 1'b1, 4'd0, 4'd1, 4'd2, 1'b0, 2'b11);
    req_valid = 4'b0001;
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_egl !== 3'b100 || req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_stall%0d got v=%b egl=%b ready=%b exp 1 100 0000", c, rsp_valid, rsp_egl, req_ready);
      end
      if (c < 4) step();
    end
    rsp_ready = 1'b1;
    step();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
      errors++; $display("FAIL bp_regrant got v=%b ready=%b exp 0 0001", rsp_valid, req_ready);
    end
    step();
    req_valid = 4'b0000;
    wait_rsp("bp");
    checks++; if (rsp_res !== 8'd3 || rsp_id !== 2'd0) begin errors++; $display("FAIL bp_next got res=%0d id=%0d exp 3 0", rsp_res, rsp_id); end
    step();
  endtask

  task automatic test_reset_mid_exec();
    logic seen;
    rsp_ready = 1'b1;
    set_req(2, 1'b1, 4'd0, 4'd7, 4'd7, 1'b0, 2'b11);
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    checks++; if (alu_ce !== 1'b1) begin errors++; $display("FAIL rx_exec alu_ce got %b exp 1", alu_ce); end
    RST = 1'b0;
    #1;
    checks++; if (alu_ce !== 1'b0 || alu_inp_valid !== 2'b00 || alu_opa !== 4'd0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rx_clear got ce=%b iv=%b opa=%0d v=%b exp 0 00 0 0", alu_ce, alu_inp_valid, alu_opa, rsp_valid);
    end
    step();
    RST = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rx_no_rsp got %b exp 0", seen); end
    set_req(0, 1'b1, 4'd0, 4'd2, 4'd2, 1'b0, 2'b11);
    set_req(2, 1'b1, 4'd0, 4'd6, 4'd1, 1'b0, 2'b11);
    req_valid = 4'b0101;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rx_regrant got %b exp 0001", req_ready); end
    step();
    req_valid = 4'b0000;
    wait_rsp("rx");
    checks++; if (rsp_res !== 8'd4 || rsp_id !== 2'd0) begin errors++; $display("FAIL rx_rsp got res=%0d id=%0d exp 4 0", rsp_res, rsp_id); end
    step();
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    pulse_reset();
    rsp_ready = 1'b1;
    set_req(1, 1'b1, 4'd0, 4'd1, 4'd1, 1'b0, 2'b11);
    for (int n = 0; n < 3; n++) begin
      req_valid = 4'b0010;
      step();
      req_valid = 4'b0000;
      wait_rsp("stat");
      step();
    end
    checks++; if (stat_grants[31:16] !== 16'd3) begin errors++; $display("FAIL stat_req1 got %0d exp 3", stat_grants[31:16]); end
    checks++; if (stat_grants[15:0] !== 16'd0 || stat_grants[63:32] !== 32'd0) begin
      errors++; $display("FAIL stat_others got %h exp 0 outside req1", stat_grants);
    end
  endtask
`endif

  initial begin
    RST           = 1'b0;
    req_valid     = '0;
    req_opa       = '0;
    req_opb       = '0;
    req_cmd       = '0;
    req_mode      = '0;
    req_cin       = '0;
    req_inp_valid = '0;
    rsp_ready     = 1'b0;
    #3;
    test_reset();
    test_single_add();
    test_round_robin();
    test_mul();
    test_back_pressure();
    test_reset_mid_exec();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
